// File: rtl/dvp_capture_v2.sv
`default_nettype none
// ============================================================================
// dvp_capture_v2 : DVP camera capture, pixel conversion, beat packing, FIFO
// Revision: 2.0
// ============================================================================
module dvp_capture_v2 #(
   parameter int C_XCLK_DIV   = 3,
   parameter int C_DATA_WIDTH = 32,
   parameter int C_FIFO_DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [1:0]                ctrl_i,
   input  logic                      ctrl_strb_i,
   output logic                      act_o,
   input  logic [1:0]                format_i,
   input  logic [31:0]               frames_set_i,
   output logic [31:0]               frames_cur_o,
   input  logic [31:0]               line_size_i,
   input  logic                      pclk_i,
   input  logic                      href_i,
   input  logic                      vsync_i,
   input  logic [9:0]                dat_i,
   output logic                      xclk_o,
   output logic                      fsync_o,
   output logic                      sof_o,
   output logic [C_DATA_WIDTH-1:0]   dat_o,
   output logic [C_DATA_WIDTH/8-1:0] dat_strb_o,
   output logic                      valid_o,
   output logic                      last_o,
   input  logic                      ready_i,
   output logic                      ovf_o
);

   localparam int BW = C_DATA_WIDTH / 8;
   localparam int FW = $clog2(BW) + 1;
   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam int EW = C_DATA_WIDTH + BW + 2;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ARMED    = 2'd1;
   localparam logic [1:0] ST_ACTIVE   = 2'd2;
   localparam logic [1:0] ST_STOPPING = 2'd3;

   function automatic logic [BW-1:0] lane_mask(input logic [FW-1:0] n);
      logic [BW-1:0] m;
      m = '0;
      for (int i = 0; i < BW; i++) m[i] = (FW'(i) < n);
      return m;
   endfunction

   // sensor master clock
   logic [7:0] xclk_cnt;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         xclk_cnt <= '0;
         xclk_o   <= 1'b0;
      end else if (xclk_cnt == 8'(C_XCLK_DIV - 1)) begin
         xclk_cnt <= '0;
         xclk_o   <= ~xclk_o;
      end else begin
         xclk_cnt <= xclk_cnt + 8'd1;
      end
   end

   logic       pclk_s1, pclk_s2, pclk_s3;
   logic       href_s1, href_s2, href_s3;
   logic       vsync_s1, vsync_s2, vsync_s3;
   logic [7:0] byte_s1, byte_s2;
   logic       unused_lsbs;
   assign unused_lsbs = ^dat_i[1:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         {pclk_s1, pclk_s2, pclk_s3}    <= '0;
         {href_s1, href_s2, href_s3}    <= '0;
         {vsync_s1, vsync_s2, vsync_s3} <= '0;
         byte_s1 <= '0;
         byte_s2 <= '0;
      end else begin
         {pclk_s1, pclk_s2, pclk_s3}    <= {pclk_i, pclk_s1, pclk_s2};
         {href_s1, href_s2, href_s3}    <= {href_i, href_s1, href_s2};
         {vsync_s1, vsync_s2, vsync_s3} <= {vsync_i, vsync_s1, vsync_s2};
         byte_s1 <= dat_i[9:2];
         byte_s2 <= byte_s1;
      end
   end

   logic pclk_rise, href_fall, vsync_rise;
   assign pclk_rise  = pclk_s2 & ~pclk_s3;
   assign href_fall  = href_s3 & ~href_s2;
   assign vsync_rise = vsync_s2 & ~vsync_s3;
   assign fsync_o    = vsync_s2;

   logic [1:0] state, state_nxt;
   logic       cmd_stop, cmd_arm, cmd_halt, frames_done;
   assign cmd_stop    = ctrl_strb_i && (ctrl_i == 2'd0);
   assign cmd_arm     = ctrl_strb_i && (ctrl_i == 2'd1);
   assign cmd_halt    = ctrl_strb_i && (ctrl_i == 2'd2);
   assign frames_done = (frames_set_i != 32'd0) && (frames_cur_o == frames_set_i);

   always_ff @(posedge clk) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // a stop strobe outranks everything, including a coincident vsync rise
   always_comb begin
      state_nxt = state;
      if (cmd_stop) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (cmd_arm) state_nxt = ST_ARMED;
            ST_ARMED:    if (vsync_rise) state_nxt = ST_ACTIVE;
            ST_ACTIVE: begin
               if (cmd_halt)                       state_nxt = ST_STOPPING;
               else if (vsync_rise && frames_done) state_nxt = ST_IDLE;
            end
            ST_STOPPING: if (vsync_rise) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      act_o = (state == ST_ACTIVE) || (state == ST_STOPPING);
   end

   logic        arm_now, frame_tick, running;
   logic [1:0]  fmt;
   logic [31:0] line_size;
   logic        sof_pend, push_now, fifo_drop;
   assign arm_now    = (state == ST_IDLE) && cmd_arm;
   assign frame_tick = vsync_rise && (state_nxt == ST_ACTIVE);
   assign running    = act_o && !cmd_stop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         frames_cur_o <= '0;
         ovf_o        <= 1'b0;
         fmt          <= '0;
         line_size    <= '0;
         sof_pend     <= 1'b0;
      end else begin
         if (arm_now) begin
            frames_cur_o <= '0;
            fmt          <= format_i;
            line_size    <= line_size_i;
         end else if (frame_tick) begin
            frames_cur_o <= frames_cur_o + 32'd1;
         end
         if (arm_now)         sof_pend <= 1'b0;
         else if (frame_tick) sof_pend <= 1'b1;
         else if (push_now)   sof_pend <= 1'b0;
         if (arm_now)         ovf_o <= 1'b0;
         else if (fifo_drop)  ovf_o <= 1'b1;
      end
   end

   logic                    take, pair_fmt, have_b0, emit_v, emit_ok, beat_end;
   logic [7:0]              b0;
   logic [2:0]              emit_n;
   logic [31:0]             emit_word, line_cnt, line_nxt;
   logic [FW-1:0]           fill, fill_nxt;
   logic [C_DATA_WIDTH-1:0] beat, beat_nxt;
   logic                    push_v;
   logic [EW-1:0]           push_entry;

   assign take     = running && pclk_rise && href_s2;
   assign pair_fmt = (fmt == 2'd0) || (fmt == 2'd2);

   always_comb begin
      emit_v    = 1'b0;
      emit_n    = 3'd1;
      emit_word = {24'h0, byte_s2};
      if (take) begin
         if (!pair_fmt) begin
            emit_v = 1'b1;
         end else if (have_b0) begin
            emit_v = 1'b1;
            if (fmt == 2'd0) begin
               emit_n    = 3'd4;
               emit_word = {8'h00, b0[7:3], 3'b000, b0[2:0], byte_s2[7:5], 2'b00,
                            byte_s2[4:0], 3'b000};
            end else begin
               emit_n    = 3'd2;
               emit_word = {16'h0, byte_s2, b0};
            end
         end
      end
   end

   // line_size is a multiple of 4, so an emitted group never straddles a beat or line end
   assign emit_ok  = emit_v && (line_cnt < line_size);
   assign fill_nxt = fill + FW'(emit_n);
   assign line_nxt = line_cnt + 32'(emit_n);
   assign beat_nxt = beat | (C_DATA_WIDTH'(emit_word) << {fill, 3'b000});
   assign beat_end = (fill_nxt == FW'(BW)) || (line_nxt == line_size);
   assign push_now = running && ((emit_ok && beat_end) || (href_fall && fill != '0));

   always_ff @(posedge clk) begin
      if (!resetn || !running) begin
         fill       <= '0;
         have_b0    <= 1'b0;
         b0         <= '0;
         line_cnt   <= '0;
         beat       <= '0;
         push_v     <= 1'b0;
         push_entry <= '0;
      end else begin
         push_v <= 1'b0;
         if (take && pair_fmt && !have_b0) begin
            b0      <= byte_s2;
            have_b0 <= 1'b1;
         end
         if (emit_v) have_b0 <= 1'b0;
         if (emit_ok) begin
            line_cnt <= line_nxt;
            if (beat_end) begin
               push_v     <= 1'b1;
               push_entry <= {beat_nxt, lane_mask(fill_nxt), line_nxt == line_size, sof_pend};
               beat       <= '0;
               fill       <= '0;
            end else begin
               beat <= beat_nxt;
               fill <= fill_nxt;
            end
         end
         if (href_fall) begin
            have_b0  <= 1'b0;
            line_cnt <= '0;
            if (fill != '0) begin
               push_v     <= 1'b1;
               push_entry <= {beat, lane_mask(fill), 1'b1, sof_pend};
               beat       <= '0;
               fill       <= '0;
            end
         end
      end
   end

   logic [EW-1:0] mem [C_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          empty, full, pop, wr_en;
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(C_FIFO_DEPTH));
   assign pop       = (!valid_o || ready_i) && !empty;
   assign wr_en     = push_v && (!full || pop);
   assign fifo_drop = push_v && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_o    <= 1'b0;
         dat_o      <= '0;
         dat_strb_o <= '0;
         last_o     <= 1'b0;
         sof_o      <= 1'b0;
      end else if (!valid_o || ready_i) begin
         valid_o <= !empty;
         if (!empty) {dat_o, dat_strb_o, last_o, sof_o} <= mem[rd_ptr];
      end
   end

endmodule
`default_nettype wire
